// File: rtl/dram_arbiter_pkg.sv
// ============================================================================
// Module   : DramArbPkg
// Purpose  : Shared types and constants for the DRAM front-end arbiter.
//            Holds the default channel/address/data geometry, the
//            arbitration-mode encoding and the default-width channel-id and
//            burst types.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package DramArbPkg;

  // Default geometry of the top level this block plugs into.
  localparam int N_TAU          = 4;
  localparam int GLOBAL_ADDR_BW = 32;
  localparam int DATA_BW        = 32;
  localparam int CACHE_SIZE     = 8;

  // Arbitration mode encoding for the RR parameter.
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef logic [$clog2(N_TAU)-1:0]           ch_id_t;
  typedef logic [CACHE_SIZE-1:0][DATA_BW-1:0] burst_t;

endpackage : DramArbPkg

`default_nettype wire

// File: rtl/dram_tag_fifo.sv
// ============================================================================
// Module   : dram_tag_fifo
// Purpose  : Synchronous FIFO of channel ids for in-flight reads. The head
//            entry names the channel that owns the next DRAM read response.
// Ports    : i_clk, i_rst (async, active high)
//            push / push_id : enqueue one channel id (ignored when full)
//            pop            : dequeue the head entry (ignored when empty)
//            full, empty    : occupancy flags
//            head           : oldest channel id
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_tag_fifo
  import DramArbPkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = $bits(ch_id_t)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : dram_tag_fifo

`default_nettype wire

// File: rtl/dram_arbiter.sv
// ============================================================================
// Module   : dram_arbiter
// Purpose  : N-channel DRAM front end. Arbitrates per-channel read-address
//            and write requests into one registered command port and routes
//            in-order read responses back to the issuing channel.
// Ports    : i_clk, i_rst (async, active high)
//            ra_rdys/ra_addrs/ra_acks       : per-channel read-address reqs
//            w_rdys/w_addrs/w_datas/w_acks  : per-channel write reqs
//            rd_rdys/rd_data/rd_acks        : per-channel read responses
//            cmd_rdy/cmd_ack/cmd_we/cmd_addr/cmd_wdata : DRAM command port
//            resp_rdy/resp_data/resp_ack    : DRAM read-response port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_arbiter
  import DramArbPkg::*;
#(
  parameter int N_CH        = N_TAU,
  parameter int ABW         = GLOBAL_ADDR_BW,
  parameter int DBW         = DATA_BW,
  parameter int CSIZE       = CACHE_SIZE,
  parameter int OUTSTANDING = 8,
  parameter int RR          = ARB_RR
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [N_CH-1:0]                       ra_rdys,
  input  logic [N_CH-1:0][ABW-1:0]              ra_addrs,
  output logic [N_CH-1:0]                       ra_acks,
  input  logic [N_CH-1:0]                       w_rdys,
  input  logic [N_CH-1:0][ABW-1:0]              w_addrs,
  input  logic [N_CH-1:0][CSIZE-1:0][DBW-1:0]   w_datas,
  output logic [N_CH-1:0]                       w_acks,
  output logic [N_CH-1:0]                       rd_rdys,
  output logic [CSIZE-1:0][DBW-1:0]             rd_data,
  input  logic [N_CH-1:0]                       rd_acks,
  output logic                                  cmd_rdy,
  input  logic                                  cmd_ack,
  output logic                                  cmd_we,
  output logic [ABW-1:0]                        cmd_addr,
  output logic [CSIZE-1:0][DBW-1:0]             cmd_wdata,
  input  logic                                  resp_rdy,
  input  logic [CSIZE-1:0][DBW-1:0]             resp_data,
  output logic                                  resp_ack
);

  localparam int              CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W:0]   N_CH_L  = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] head;
  logic [CH_W:0]   scan_idx;
  logic [N_CH-1:0] eligible;
  logic            grant_found;
  logic            grant_valid;
  logic            grant_is_wr;
  logic            can_load;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            resp_live;

  // A full tag FIFO masks reads only; writes never need a tag.
  assign eligible = w_rdys | (ra_rdys & {N_CH{~fifo_full}});
  assign can_load = ~cmd_rdy | cmd_ack;

  // Scan from the rotating pointer (round-robin) or from channel 0 (fixed).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < N_CH; i++) begin
      scan_idx = (RR == ARB_RR) ? ({1'b0, ptr} + (CH_W+1)'(i)) : (CH_W+1)'(i);
      if (scan_idx >= N_CH_L) begin
        scan_idx = scan_idx - N_CH_L;
      end
      if (!grant_found && eligible[scan_idx[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[CH_W-1:0];
      end
    end
  end

  // Acks are combinational; gating with reset keeps them low while the
  // asynchronous reset is held, even if requesters are still raised.
  assign grant_valid = ~i_rst & can_load & grant_found;
  assign grant_is_wr = w_rdys[grant_idx];
  assign push        = grant_valid & ~grant_is_wr;

  always_comb begin
    ra_acks = '0;
    w_acks  = '0;
    if (grant_valid) begin
      if (grant_is_wr) begin
        w_acks[grant_idx] = 1'b1;
      end else begin
        ra_acks[grant_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cmd_rdy   <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      ptr       <= '0;
    end else begin
      if (grant_valid) begin
        cmd_rdy   <= 1'b1;
        cmd_we    <= grant_is_wr;
        cmd_addr  <= grant_is_wr ? w_addrs[grant_idx] : ra_addrs[grant_idx];
        cmd_wdata <= grant_is_wr ? w_datas[grant_idx] : '0;
        if (RR == ARB_RR) begin
          ptr <= (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
        end
      end else if (cmd_ack) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  dram_tag_fifo #(
    .DEPTH (OUTSTANDING),
    .W     (CH_W)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push    (push),
    .push_id (grant_idx),
    .pop     (resp_ack),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  // Response path is purely combinational: the head tag steers the
  // broadcast burst to exactly one channel.
  assign resp_live = resp_rdy & ~fifo_empty;
  assign rd_data   = resp_data;
  assign resp_ack  = resp_live & rd_acks[head];

  always_comb begin
    rd_rdys = '0;
    for (int c = 0; c < N_CH; c++) begin
      rd_rdys[c] = resp_live & (head == CH_W'(c));
    end
  end

  // A response with no read in flight means the DRAM side is out of step.
  a_no_orphan_resp : assert property (@(posedge i_clk) disable iff (i_rst)
    !(resp_rdy && fifo_empty));

endmodule : dram_arbiter

`default_nettype wire

// File: tb/tb_dram_arbiter.sv
// ============================================================================
// Module   : tb_dram_arbiter
// Purpose  : Self-checking bench for dram_arbiter. A round-robin instance is
//            driven by randomized requesters and a DRAM responder and checked
//            every cycle against a queue-based model; a fixed-priority
//            instance is exercised with directed requests.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_arbiter;

  localparam int N   = 4;
  localparam int ABW = 16;
  localparam int DBW = 16;
  localparam int CS  = 2;
  localparam int OUT = 8;

  typedef logic [CS-1:0][DBW-1:0] bt;
  typedef struct { int ch; logic [ABW-1:0] addr; } tag_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Round-robin instance signals
  logic [N-1:0]          ra_rdys, ra_acks, w_rdys, w_acks, rd_rdys, rd_acks;
  logic [N-1:0][ABW-1:0] ra_addrs, w_addrs;
  logic [N-1:0][CS-1:0][DBW-1:0] w_datas;
  bt                     rd_data, cmd_wdata, resp_data;
  logic                  cmd_rdy, cmd_ack, cmd_we, resp_rdy, resp_ack;
  logic [ABW-1:0]        cmd_addr;

  // Fixed-priority instance signals
  logic [N-1:0]          f_ra_rdys, f_ra_acks, f_w_rdys, f_w_acks, f_rd_rdys;
  logic [N-1:0][ABW-1:0] f_ra_addrs, f_w_addrs;
  logic [N-1:0][CS-1:0][DBW-1:0] f_w_datas;
  bt                     f_rd_data, f_cmd_wdata;
  logic                  f_cmd_rdy, f_cmd_ack, f_cmd_we, f_resp_ack;
  logic [ABW-1:0]        f_cmd_addr;

  dram_arbiter #(.N_CH(N), .ABW(ABW), .DBW(DBW), .CSIZE(CS),
                 .OUTSTANDING(OUT), .RR(1)) u_rr (
    .i_clk(clk), .i_rst(rst),
    .ra_rdys(ra_rdys), .ra_addrs(ra_addrs), .ra_acks(ra_acks),
    .w_rdys(w_rdys), .w_addrs(w_addrs), .w_datas(w_datas), .w_acks(w_acks),
    .rd_rdys(rd_rdys), .rd_data(rd_data), .rd_acks(rd_acks),
    .cmd_rdy(cmd_rdy), .cmd_ack(cmd_ack), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .resp_rdy(resp_rdy), .resp_data(resp_data), .resp_ack(resp_ack)
  );

  dram_arbiter #(.N_CH(N), .ABW(ABW), .DBW(DBW), .CSIZE(CS),
                 .OUTSTANDING(OUT), .RR(0)) u_fp (
    .i_clk(clk), .i_rst(rst),
    .ra_rdys(f_ra_rdys), .ra_addrs(f_ra_addrs), .ra_acks(f_ra_acks),
    .w_rdys(f_w_rdys), .w_addrs(f_w_addrs), .w_datas(f_w_datas),
    .w_acks(f_w_acks),
    .rd_rdys(f_rd_rdys), .rd_data(f_rd_data), .rd_acks(4'b0000),
    .cmd_rdy(f_cmd_rdy), .cmd_ack(f_cmd_ack), .cmd_we(f_cmd_we),
    .cmd_addr(f_cmd_addr), .cmd_wdata(f_cmd_wdata),
    .resp_rdy(1'b0), .resp_data('0), .resp_ack(f_resp_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // DRAM content: each address maps to a distinct, recognisable burst.
  function automatic bt burst_of(logic [ABW-1:0] a);
    bt b;
    for (int w = 0; w < CS; w++) b[w] = a ^ DBW'(16'h1357 * (w + 1));
    return b;
  endfunction

  // ---------------- behavioural model ----------------
  tag_t           tagq[$];   // accepted reads, oldest first
  logic [ABW-1:0] dramq[$];  // reads the DRAM has taken, awaiting response
  bit             m_cv = 0, m_cwe = 0;
  logic [ABW-1:0] m_caddr = '0;
  bt              m_cwd = '0;
  int             m_ptr = 0;
  logic [N-1:0]   m_ra_ack = '0, m_w_ack = '0;
  bit             m_resp_ack = 0;

  task automatic model_cycle();
    logic [N-1:0] elig, era, ew, erd;
    bit full, cl, eack, wr;
    int g, hd;
    full = (tagq.size() >= OUT);
    for (int c = 0; c < N; c++) elig[c] = w_rdys[c] | (ra_rdys[c] & !full);
    cl = !m_cv || cmd_ack;
    g  = -1;
    if (cl) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (g < 0 && elig[c]) g = c;
      end
    end
    era = '0; ew = '0; wr = 0;
    if (g >= 0) begin
      wr = w_rdys[g];
      if (wr) ew[g] = 1'b1; else era[g] = 1'b1;
    end
    erd = '0; eack = 0;
    if (resp_rdy && tagq.size() > 0) begin
      hd = tagq[0].ch;
      erd[hd] = 1'b1;
      eack = rd_acks[hd];
    end
    check("ra_acks", 64'(ra_acks), 64'(era));
    check("w_acks", 64'(w_acks), 64'(ew));
    check("rd_rdys", 64'(rd_rdys), 64'(erd));
    check("resp_ack", 64'(resp_ack), 64'(eack));
    check("cmd_rdy", 64'(cmd_rdy), 64'(m_cv));
    if (m_cv) begin
      check("cmd_we", 64'(cmd_we), 64'(m_cwe));
      check("cmd_addr", 64'(cmd_addr), 64'(m_caddr));
      if (m_cwe) check("cmd_wdata", 64'(cmd_wdata), 64'(m_cwd));
    end
    if (eack) check("rd_data", 64'(rd_data), 64'(burst_of(tagq[0].addr)));
    // advance to the state after the coming clock edge
    if (eack) begin
      void'(tagq.pop_front());
      void'(dramq.pop_front());
    end
    if (m_cv && cmd_ack && !m_cwe) dramq.push_back(m_caddr);
    if (g >= 0) begin
      m_cv    = 1;
      m_cwe   = wr;
      m_caddr = wr ? w_addrs[g] : ra_addrs[g];
      m_cwd   = w_datas[g];
      m_ptr   = (g + 1) % N;
      if (!wr) tagq.push_back('{g, ra_addrs[g]});
    end else if (cmd_ack) begin
      m_cv = 0;
    end
    m_ra_ack   = era;
    m_w_ack    = ew;
    m_resp_ack = eack;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      tagq.delete(); dramq.delete();
      m_cv = 0; m_cwe = 0; m_caddr = '0; m_cwd = '0; m_ptr = 0;
      m_ra_ack = '0; m_w_ack = '0; m_resp_ack = 0;
    end else begin
      model_cycle();
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] rd_en = '0, wr_en = '0;
  int rd_prob = 0, wr_prob = 0, ack_prob = 0, resp_prob = 0, rdack_prob = 0;

  task automatic step();
    @(posedge clk); #1;
    for (int c = 0; c < N; c++) begin
      if (ra_rdys[c] && m_ra_ack[c]) ra_rdys[c] = 1'b0;
      if (!ra_rdys[c] && rd_en[c] && ($urandom_range(99) < rd_prob)) begin
        ra_rdys[c] = 1'b1; ra_addrs[c] = ABW'($urandom);
      end
      if (w_rdys[c] && m_w_ack[c]) w_rdys[c] = 1'b0;
      if (!w_rdys[c] && wr_en[c] && ($urandom_range(99) < wr_prob)) begin
        w_rdys[c] = 1'b1; w_addrs[c] = ABW'($urandom); w_datas[c] = bt'($urandom);
      end
      rd_acks[c] = ($urandom_range(99) < rdack_prob);
    end
    cmd_ack = ($urandom_range(99) < ack_prob);
    if (!(resp_rdy && !m_resp_ack))
      resp_rdy = (dramq.size() > 0) && ($urandom_range(99) < resp_prob);
    resp_data = (dramq.size() > 0) ? burst_of(dramq[0]) : '0;
    @(negedge clk); #1;
  endtask

  task automatic set_probs(logic [N-1:0] re, logic [N-1:0] we, int rp, int wp,
                           int ap, int sp, int kp);
    rd_en = re; wr_en = we; rd_prob = rp; wr_prob = wp;
    ack_prob = ap; resp_prob = sp; rdack_prob = kp;
  endtask

  initial begin
    rst = 1'b1;
    ra_rdys = '0; ra_addrs = '0; w_rdys = '0; w_addrs = '0; w_datas = '0;
    rd_acks = '0; cmd_ack = 1'b0; resp_rdy = 1'b0; resp_data = '0;
    f_ra_rdys = '0; f_ra_addrs = '0; f_w_rdys = '0; f_w_addrs = '0;
    f_w_datas = '0; f_cmd_ack = 1'b0;
    f_ra_addrs[1] = 16'h1111; f_ra_addrs[3] = 16'h3333;
    f_w_addrs[1]  = 16'hA1A1; f_w_addrs[3]  = 16'hA3A3;
    step(); step();
    // reset values
    check("rst_cmd_rdy", 64'(cmd_rdy), 0);
    check("rst_cmd_we", 64'(cmd_we), 0);
    check("rst_cmd_addr", 64'(cmd_addr), 0);
    check("rst_cmd_wdata", 64'(cmd_wdata), 0);
    check("rst_acks", 64'({ra_acks, w_acks}), 0);
    check("rst_rd_rdys", 64'(rd_rdys), 0);
    rst = 1'b0;

    // fixed priority: channel 1 starves channel 3
    f_cmd_ack = 1'b1; f_w_rdys = 4'b1010;
    repeat (3) begin step(); check("fp_w_ch1", 64'(f_w_acks), 64'h2); end
    f_w_rdys = 4'b1000;
    step(); check("fp_w_ch3", 64'(f_w_acks), 64'h8);
    f_w_rdys = 4'b0000; f_ra_rdys = 4'b1010;
    repeat (3) begin step(); check("fp_ra_ch1", 64'(f_ra_acks), 64'h2); end
    step();
    check("fp_cmd_we", 64'(f_cmd_we), 0);
    check("fp_cmd_addr1", 64'(f_cmd_addr), 64'h1111);
    f_ra_rdys = 4'b1000;
    step(); check("fp_ra_ch3", 64'(f_ra_acks), 64'h8);
    step(); check("fp_cmd_addr3", 64'(f_cmd_addr), 64'h3333);
    f_ra_rdys = 4'b0000; f_cmd_ack = 1'b0;

    // round-robin order, then tag FIFO full
    set_probs(4'b1111, 4'b0000, 100, 0, 100, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(); check("rr_order", 64'(ra_acks), 64'(1 << (k % 4)));
    end
    step(); check("full_no_read", 64'(ra_acks), 0);
    set_probs(4'b1111, 4'b0100, 100, 100, 100, 0, 0);
    step();
    check("full_write_ack", 64'(w_acks), 64'h4);
    check("full_read_masked", 64'(ra_acks), 0);
    step(); check("full_cmd_we", 64'(cmd_we), 1);

    // response routing: head held while its channel does not consume
    set_probs(4'b0000, 4'b0000, 0, 0, 100, 100, 0);
    repeat (3) begin
      step();
      check("rt_hold_rdys", 64'(rd_rdys), 64'h1);
      check("rt_hold_ack", 64'(resp_ack), 0);
    end
    rdack_prob = 100;
    step();
    check("rt_pop_ack", 64'(resp_ack), 1);
    check("rt_pop_rdys", 64'(rd_rdys), 64'h1);
    step(); check("rt_next_head", 64'(rd_rdys), 64'h2);
    repeat (10) step();

    // backpressure: command held, no further upstream acks
    set_probs(4'b1111, 4'b1111, 100, 100, 0, 0, 100);
    step(); check("bp_first_grant", 64'(|(ra_acks | w_acks)), 1);
    repeat (5) begin
      step();
      check("bp_no_ack", 64'({ra_acks, w_acks}), 0);
      check("bp_cmd_rdy", 64'(cmd_rdy), 1);
    end

    // randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      set_probs(4'($urandom), 4'($urandom), $urandom_range(20, 90),
                $urandom_range(10, 60), $urandom_range(30, 100),
                $urandom_range(30, 100), $urandom_range(30, 100));
      repeat (100) step();
    end

    // drain, then reset with reads outstanding
    begin
      int t;
      set_probs(4'b0000, 4'b0000, 0, 0, 100, 100, 100);
      t = 0;
      while ((tagq.size() > 0 || m_cv) && t < 300) begin step(); t++; end
      check("drain_in_time", 64'(t < 300), 1);
      set_probs(4'b1111, 4'b0000, 100, 0, 100, 0, 100);
      t = 0;
      while (!(tagq.size() >= 3 && m_ptr != 0) && t < 20) begin step(); t++; end
      check("fill_in_time", 64'(t < 20), 1);
    end
    set_probs(4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_cmd_rdy", 64'(cmd_rdy), 0);
    check("mid_rst_cmd_addr", 64'(cmd_addr), 0);
    check("mid_rst_cmd_we", 64'(cmd_we), 0);
    check("mid_rst_acks", 64'({ra_acks, w_acks}), 0);
    ra_rdys = '0; w_rdys = '0; resp_rdy = 1'b0; cmd_ack = 1'b0; rd_acks = '0;
    #1;
    check("mid_rst_rd_rdys", 64'(rd_rdys), 0);
    step(); step();
    rst = 1'b0;
    set_probs(4'b1111, 4'b0000, 100, 0, 100, 0, 0);
    step(); check("post_rst_grant0", 64'(ra_acks), 64'h1);
    step(); check("post_rst_grant1", 64'(ra_acks), 64'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dram_arbiter

`default_nettype wire
